// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder
//   Reads a multiplexed active-low seven-segment bus and recovers the hex digit
//   shown on each anode position. A digit is taken only after its anode/segment
//   pair has been stable long enough. A frame is published once every position
//   has been seen.
//
// Optional build macro: SEVSEG_ERRCNT_EN adds the err_count output.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   an           anode enables, active-low, bit k = digit k
//   seg          segment lines, active-low, bit6 = a ... bit0 = g
//   hex_value    decoded nibbles, digit k at [4k+3:4k]
//   blank_mask   digit k was blank
//   err_mask     digit k showed an unknown pattern
//   frame_valid  one-cycle pulse, the three masks/values update on the same edge
//   err_count    (SEVSEG_ERRCNT_EN only) saturating count of invalid accepts
module sevenseg_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] hex_value,
    output logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [NUM_DIGITS-1:0]   err_mask,
    output logic                    frame_valid
`ifdef SEVSEG_ERRCNT_EN
   ,output logic [7:0]              err_count
`endif
);

    localparam int unsigned SEG_W = 7;
    localparam int unsigned NIB_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_PUBLISH = 1'b1
    } state_t;

    logic [NUM_DIGITS-1:0]            an_q;
    logic [SEG_W-1:0]                 seg_q;
    logic [CNT_W-1:0]                 cnt;
    logic                             taken;
    logic [NUM_DIGITS-1:0]            seen;
    logic [NUM_DIGITS-1:0][NIB_W-1:0] cap_nib;
    logic [NUM_DIGITS-1:0]            cap_blank;
    logic [NUM_DIGITS-1:0]            cap_err;
    state_t                           state;
    state_t                           state_next;
    logic                             load_out;
    logic                             clear_seen;

    logic                             changed;
    logic [NUM_DIGITS-1:0]            digit_sel;
    logic                             one_low;
    logic                             accept;
    logic [NIB_W-1:0]                 dec_nib;
    logic                             dec_blank;
    logic                             dec_err;

    // The pins are compared against the current sample so the counter restarts
    // on the same edge that registers a new value.
    assign changed   = ({an, seg} != {an_q, seg_q});
    assign digit_sel = ~an_q;
    assign one_low   = (digit_sel != '0) &&
                       ((digit_sel & (digit_sel - NUM_DIGITS'(1))) == '0);
    assign accept    = (cnt == CNT_LAST) && !taken && one_low;

    // Input register and stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= '1;
            seg_q <= '1;
            cnt   <= '0;
            taken <= 1'b0;
        end else begin
            an_q  <= an;
            seg_q <= seg;
            if (changed) begin
                cnt   <= '0;
                taken <= 1'b0;
            end else begin
                if (cnt != CNT_LAST) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (accept) begin
                    taken <= 1'b1;
                end
            end
        end
    end

    // Segment pattern to nibble decode
    always_comb begin
        dec_nib   = '0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg_q)
            7'b0000001: dec_nib = 4'h0;
            7'b1001111: dec_nib = 4'h1;
            7'b0010010: dec_nib = 4'h2;
            7'b0000110: dec_nib = 4'h3;
            7'b1001100: dec_nib = 4'h4;
            7'b0100100: dec_nib = 4'h5;
            7'b0100000: dec_nib = 4'h6;
            7'b0001111: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0000100: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b1100000: dec_nib = 4'hB;
            7'b0110001: dec_nib = 4'hC;
            7'b1000010: dec_nib = 4'hD;
            7'b0110000: dec_nib = 4'hE;
            7'b0111000: dec_nib = 4'hF;
            7'b1111111: dec_blank = 1'b1;
            default:    dec_err   = 1'b1;
        endcase
    end

    // Per-digit capture and seen mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_nib   <= '0;
            cap_blank <= '0;
            cap_err   <= '0;
            seen      <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                if (accept && digit_sel[k]) begin
                    cap_nib[k]   <= dec_nib;
                    cap_blank[k] <= dec_blank;
                    cap_err[k]   <= dec_err;
                end
            end
            // An accept during publish lands in the freshly cleared mask.
            if (clear_seen) begin
                seen <= accept ? digit_sel : '0;
            end else if (accept) begin
                seen <= seen | digit_sel;
            end
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Frame FSM next-state; outputs load on the edge that enters PUBLISH
    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        clear_seen = 1'b0;
        case (state)
            S_COLLECT: begin
                if (&seen) begin
                    state_next = S_PUBLISH;
                    load_out   = 1'b1;
                end
            end
            S_PUBLISH: begin
                clear_seen = 1'b1;
                state_next = S_COLLECT;
            end
            default: state_next = S_COLLECT;
        endcase
    end

    // Published outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_value   <= '0;
            blank_mask  <= '0;
            err_mask    <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= load_out;
            if (load_out) begin
                hex_value  <= cap_nib;
                blank_mask <= cap_blank;
                err_mask   <= cap_err;
            end
        end
    end

`ifdef SEVSEG_ERRCNT_EN
    // Saturating count of accepted invalid patterns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (accept && dec_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Scoreboard bench for sevenseg_scan_decoder: stimulus is a list of pin holds,
// a hold-level model predicts frames, a monitor checks them as they appear.
module tb_sevenseg_scan_decoder;

    localparam int unsigned ND = 4;
    localparam int unsigned S  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] hex_value;
    logic [3:0]  blank_mask;
    logic [3:0]  err_mask;
    logic        frame_valid;
`ifdef SEVSEG_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    sevenseg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S), .CNT_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .seg         (seg),
        .hex_value   (hex_value),
        .blank_mask  (blank_mask),
        .err_mask    (err_mask),
        .frame_valid (frame_valid)
`ifdef SEVSEG_ERRCNT_EN
       ,.err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [15:0] hex;
        logic [3:0]  blank;
        logic [3:0]  err;
        int unsigned at;
    } frame_t;

    frame_t exp_q[$];

    logic [6:0] ctab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Model state
    logic [3:0]  m_nib [4];
    logic [3:0]  m_blank, m_err, m_seen;
    logic [15:0] m_out_hex;
    logic [3:0]  m_out_blank, m_out_err;
    logic [3:0]  prev_an;
    logic [6:0]  prev_seg;
    int unsigned m_errs;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
        m_blank = '0; m_err = '0; m_seen = '0;
        m_out_hex = '0; m_out_blank = '0; m_out_err = '0;
        prev_an = 4'hF; prev_seg = 7'h7F;
        m_errs = 0;
    endtask

    task automatic lookup(input logic [6:0] s, output logic [3:0] nib,
                          output logic blank, output logic err);
        nib = 4'h0; blank = (s == 7'h7F); err = !blank;
        for (int i = 0; i < 16; i++)
            if (!blank && ctab[i] == s) begin nib = 4'(i); err = 1'b0; end
    endtask

    // Drive one pin hold of d cycles, starting just after a rising edge.
    task automatic apply_hold(input logic [3:0] a, input logic [6:0] s, input int unsigned d);
        int unsigned start;
        int          k;
        logic [3:0]  nib;
        logic        bl, er;
        frame_t      f;
        an = a; seg = s;
        start = cyc;
        if (d >= S && $countones(~a) == 1) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (!a[i]) k = i;
            lookup(s, nib, bl, er);
            m_nib[k] = nib; m_blank[k] = bl; m_err[k] = er;
            m_seen[k] = 1'b1;
            if (er) m_errs++;
            if (m_seen == 4'hF) begin
                f.hex   = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                f.blank = m_blank;
                f.err   = m_err;
                f.at    = start + S + 2;
                exp_q.push_back(f);
                m_out_hex = f.hex; m_out_blank = f.blank; m_out_err = f.err;
                m_seen = '0;
            end
        end
        prev_an = a; prev_seg = s;
        repeat (d) @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare whenever a frame is presented
    logic prev_fv = 1'b0;
    always @(negedge clk) begin
        frame_t f;
        if (rst_n) begin
            if (frame_valid) begin
                check("fv_single_cycle", {31'd0, prev_fv}, 32'd0);
                check("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    f = exp_q.pop_front();
                    check("hex_value", {16'd0, hex_value}, {16'd0, f.hex});
                    check("blank_mask", {28'd0, blank_mask}, {28'd0, f.blank});
                    check("err_mask", {28'd0, err_mask}, {28'd0, f.err});
                    check("frame_time", cyc, f.at);
                end
            end
            prev_fv <= frame_valid;
        end else begin
            prev_fv <= 1'b0;
        end
    end

    initial begin
        logic [3:0] a;
        logic [6:0] s;
        int unsigned d;

        model_reset();
        an = 4'hF; seg = 7'h7F; rst_n = 1'b0;
        #12;
        check("rst_hex", {16'd0, hex_value}, 32'd0);
        check("rst_blank", {28'd0, blank_mask}, 32'd0);
        check("rst_err", {28'd0, err_mask}, 32'd0);
        check("rst_fv", {31'd0, frame_valid}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;

        // Plain frame 4321
        apply_hold(4'b1110, ctab[1], 20);
        apply_hold(4'b1101, ctab[2], 20);
        apply_hold(4'b1011, ctab[3], 20);
        apply_hold(4'b0111, ctab[4], 20);
        // Blank on digit 2
        apply_hold(4'b1110, ctab[1], 20);
        apply_hold(4'b1101, ctab[2], 20);
        apply_hold(4'b1011, 7'h7F, 20);
        apply_hold(4'b0111, ctab[4], 20);
        // Invalid pattern on digit 1
        apply_hold(4'b1110, ctab[1], 20);
        apply_hold(4'b1101, 7'b1010101, 20);
        apply_hold(4'b1011, ctab[3], 20);
        apply_hold(4'b0111, ctab[4], 20);
        // Glitch on digit 0 before the real value
        apply_hold(4'b1110, ctab[8], 10);
        apply_hold(4'b1110, ctab[1], 20);
        apply_hold(4'b1101, ctab[2], 20);
        apply_hold(4'b1011, ctab[3], 20);
        apply_hold(4'b0111, ctab[4], 20);
        // Two anodes low, then all high: never accepted
        apply_hold(4'b1100, ctab[2], 40);
        apply_hold(4'b1111, 7'h7F, 40);
        apply_hold(4'b1111, ctab[3], 40);

        // Three digits, then an asynchronous reset mid-cycle
        apply_hold(4'b1110, ctab[5], 20);
        apply_hold(4'b1101, ctab[6], 20);
        apply_hold(4'b1011, ctab[7], 20);
        apply_hold(4'b1111, 7'h7F, 4);
        check("pre_rst_queue_empty", exp_q.size(), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_hex", {16'd0, hex_value}, 32'd0);
        check("async_rst_blank", {28'd0, blank_mask}, 32'd0);
        check("async_rst_err", {28'd0, err_mask}, 32'd0);
        check("async_rst_fv", {31'd0, frame_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        @(posedge clk) #1;

        // After reset all four digits are needed again
        apply_hold(4'b1110, ctab[9], 20);
        apply_hold(4'b1101, ctab[10], 20);
        apply_hold(4'b1011, ctab[11], 20);
        apply_hold(4'b0111, ctab[12], 20);

        // Randomized holds
        for (int n = 0; n < 80; n++) begin
            do begin
                case ($urandom_range(0, 9))
                    0, 1:    a = 4'hF;
                    2:       a = 4'($urandom);
                    default: a = ~(4'b0001 << $urandom_range(0, 3));
                endcase
                case ($urandom_range(0, 9))
                    0, 1:    s = 7'h7F;
                    2, 3:    s = 7'($urandom);
                    default: s = ctab[$urandom_range(0, 15)];
                endcase
            end while ({a, s} == {prev_an, prev_seg});
            d = ($urandom_range(0, 1) != 0) ? $urandom_range(S, S + 10)
                                            : $urandom_range(1, S + 2);
            apply_hold(a, s, d);
        end

        // Drain: idle long enough for any pending frame
        if (prev_an == 4'hF && prev_seg == 7'h7F) apply_hold(4'hF, 7'h7E, S + 6);
        else                                      apply_hold(4'hF, 7'h7F, S + 6);
        check("queue_drained", exp_q.size(), 32'd0);
        check("hold_hex", {16'd0, hex_value}, {16'd0, m_out_hex});
        check("hold_blank", {28'd0, blank_mask}, {28'd0, m_out_blank});
        check("hold_err", {28'd0, err_mask}, {28'd0, m_out_err});
`ifdef SEVSEG_ERRCNT_EN
        check("err_count", {24'd0, err_count}, (m_errs > 255) ? 32'd255 : m_errs);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
